// File: rtl/debounce8.sv
// Eight-channel switch debouncer: per-bit two-flop synchronizer and agreement
// counter, registered per-bit change pulses, and a sticky power-up VALID flag.
module debounce8 #(
   parameter int         DEBOUNCE  = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] I,
   output logic [7:0] O,
   output logic [7:0] CHANGED,
   output logic       VALID
);

   localparam int            CW         = $clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
   localparam int            VW         = $clog2(DEBOUNCE + 2);
   localparam logic [VW-1:0] VALID_LAST = VW'(DEBOUNCE + 1);

   logic rst_meta_reg;
   logic rst_int_reg;

   // Reset asserts immediately but releases two edges later, so every
   // downstream flop leaves reset on the same clock edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rst_meta_reg <= 1'b1;
         rst_int_reg  <= 1'b1;
      end else begin
         rst_meta_reg <= 1'b0;
         rst_int_reg  <= rst_meta_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         logic          s1_reg;
         logic          s2_reg;
         logic          o_reg;
         logic          o_next;
         logic          chg_reg;
         logic          chg_next;
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;

         // Any agreeing edge clears the count, so a glitch restarts the window.
         always_comb begin
            cnt_next = '0;
            o_next   = o_reg;
            chg_next = 1'b0;
            if (s2_reg != o_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  o_next   = s2_reg;
                  chg_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         always_ff @(posedge CLK or posedge rst_int_reg) begin
            if (rst_int_reg) begin
               s1_reg  <= RESET_VAL[gi];
               s2_reg  <= RESET_VAL[gi];
               o_reg   <= RESET_VAL[gi];
               cnt_reg <= '0;
               chg_reg <= 1'b0;
            end else begin
               s1_reg  <= I[gi];
               s2_reg  <= s1_reg;
               o_reg   <= o_next;
               cnt_reg <= cnt_next;
               chg_reg <= chg_next;
            end
         end

         assign O[gi]       = o_reg;
         assign CHANGED[gi] = chg_reg;
      end
   endgenerate

   logic [VW-1:0] win_cnt_reg;
   logic [VW-1:0] win_cnt_next;
   logic          valid_reg;
   logic          valid_next;

   // Free-running first-window timer; matches the latency of a bit that was
   // stable from the first sampling edge.
   always_comb begin
      win_cnt_next = win_cnt_reg;
      valid_next   = valid_reg;
      if (!valid_reg) begin
         if (win_cnt_reg == VALID_LAST) begin
            valid_next = 1'b1;
         end else begin
            win_cnt_next = win_cnt_reg + VW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge rst_int_reg) begin
      if (rst_int_reg) begin
         win_cnt_reg <= '0;
         valid_reg   <= 1'b0;
      end else begin
         win_cnt_reg <= win_cnt_next;
         valid_reg   <= valid_next;
      end
   end

   assign VALID = valid_reg;

endmodule

// File: tb/tb_debounce8.sv
// Scoreboard bench for debounce8 with DEBOUNCE=4. Edge 1 is the first clock
// edge after the internal release synchronizer lets the design out of reset.
module tb_debounce8;

   logic       CLK;
   logic       RESET;
   logic [7:0] I;
   logic [7:0] O;
   logic [7:0] CHANGED;
   logic       VALID;

   typedef struct packed {
      logic [7:0] o;
      logic [7:0] chg;
      logic       vld;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   debounce8 #(.DEBOUNCE(4), .RESET_VAL(8'h00)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .I       (I),
      .O       (O),
      .CHANGED (CHANGED),
      .VALID   (VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required end of test");
      $fatal(1, "watchdog");
   end

   function automatic string fmt(obs_t v);
      return $sformatf("O=%h CHANGED=%h VALID=%b", v.o, v.chg, v.vld);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset(input logic [7:0] ival);
      I     = ival;
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_idle(input logic [7:0] ival, input int n);
      I = ival;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      obs_t want;
      obs_t got;
      RESET = 1'b0;
      I     = 8'hFF;
      #1 RESET = 1'b1;
      #2;
      got = {O, CHANGED, VALID};
      n_cmp++;
      if (got !== 17'h0) begin
         n_bad++;
         $display("FAIL reset_async: got %s, want O=00 CHANGED=00 VALID=0", fmt(got));
      end else $display("[reset_async] %s", fmt(got));
      repeat (3) tick();
      got = {O, CHANGED, VALID};
      n_cmp++;
      if (got !== 17'h0) begin
         n_bad++;
         $display("FAIL reset_held: got %s, want O=00 CHANGED=00 VALID=0", fmt(got));
      end else $display("[reset_held] %s", fmt(got));
      RESET = 1'b0;
      tick();
      tick();
      for (int k = 1; k <= 8; k++) begin
         I        = 8'hFF;
         want.o   = (k >= 6) ? 8'hFF : 8'h00;
         want.chg = (k == 6) ? 8'hFF : 8'h00;
         want.vld = (k >= 6);
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL reset_release edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[reset_release] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   task automatic test_glitch_reject();
      obs_t want;
      obs_t got;
      apply_reset(8'h00);
      run_idle(8'h00, 8);
      for (int k = 1; k <= 12; k++) begin
         I        = (k <= 3) ? 8'h08 : 8'h00;
         want.o   = 8'h00;
         want.chg = 8'h00;
         want.vld = 1'b1;
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL glitch_reject edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[glitch_reject] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   task automatic test_toggle();
      obs_t want;
      obs_t got;
      logic b;
      // toggles land before edges 1,3,5,7,9; the last one (to 1) is held
      for (int k = 1; k <= 18; k++) begin
         b        = (k >= 9) || (k == 1) || (k == 2) || (k == 5) || (k == 6);
         I        = {7'b0, b};
         want.o   = (k >= 14) ? 8'h01 : 8'h00;
         want.chg = (k == 14) ? 8'h01 : 8'h00;
         want.vld = 1'b1;
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL toggle edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[toggle] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   task automatic test_staggered();
      obs_t want;
      obs_t got;
      apply_reset(8'h00);
      run_idle(8'h00, 8);
      for (int k = 1; k <= 10; k++) begin
         I        = {5'b0, (k >= 3), 1'b1, 1'b0};
         want.o   = {5'b0, (k >= 8), (k >= 6), 1'b0};
         want.chg = {5'b0, (k == 8), (k == 6), 1'b0};
         want.vld = 1'b1;
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL staggered edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[staggered] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   task automatic test_falling();
      obs_t want;
      obs_t got;
      run_idle(8'hFF, 8);
      for (int k = 1; k <= 8; k++) begin
         I        = 8'h7F;
         want.o   = (k >= 6) ? 8'h7F : 8'hFF;
         want.chg = (k == 6) ? 8'h80 : 8'h00;
         want.vld = 1'b1;
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL falling edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[falling] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   task automatic test_reset_mid_window();
      obs_t want;
      obs_t got;
      for (int k = 1; k <= 3; k++) begin
         I        = 8'hFF;
         want.o   = 8'h7F;
         want.chg = 8'h00;
         want.vld = 1'b1;
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL mid_window edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[mid_window] edge %0d I=%h %s", k, I, fmt(got));
      end
      RESET = 1'b1;
      #2;
      got = {O, CHANGED, VALID};
      n_cmp++;
      if (got !== 17'h0) begin
         n_bad++;
         $display("FAIL reset_mid_async: got %s, want O=00 CHANGED=00 VALID=0", fmt(got));
      end else $display("[reset_mid_async] %s", fmt(got));
      tick();
      RESET = 1'b0;
      tick();
      tick();
      for (int k = 1; k <= 8; k++) begin
         I        = 8'hFF;
         want.o   = (k >= 6) ? 8'hFF : 8'h00;
         want.chg = (k == 6) ? 8'hFF : 8'h00;
         want.vld = (k >= 6);
         exp_q.push_back(want);
         tick();
         got  = {O, CHANGED, VALID};
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL mid_release edge %0d: got %s, want %s", k, fmt(got), fmt(want));
         end else $display("[mid_release] edge %0d I=%h %s", k, I, fmt(got));
      end
   endtask

   initial begin
      test_reset();
      test_glitch_reject();
      test_toggle();
      test_staggered();
      test_falling();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
